// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/forwarding controller.
// Slot fields are sized for the widest supported register index. Narrower
// configurations zero-extend into them.
package pipe_ctrl_pkg;

   localparam int MAX_REG_BITS   = 8;
   localparam int MAX_FWD_STAGES = 6;

   // Operand source select: 0 = register file, k = forwarded from slot k.
   typedef logic [2:0] sel_t;
   localparam sel_t SEL_RF = 3'd0;

   // One in-flight instruction as tracked by the scoreboard shift register.
   typedef struct packed {
      logic                    valid;
      logic [MAX_REG_BITS-1:0] dest;
      logic                    wb_en;
      logic                    is_load;
      logic [MAX_REG_BITS-1:0] src1;
      logic [MAX_REG_BITS-1:0] src2;
      logic                    use2;
   } slot_t;

   localparam slot_t SLOT_EMPTY = '0;

   // Maps a slot index onto the operand select encoding.
   function automatic sel_t slot_sel(input int k);
      return sel_t'(k);
   endfunction

   // Legal parameter combinations for the controller.
   function automatic bit params_ok(input int reg_bits, input int fwd_stages, input int load_lat);
      return (reg_bits >= 1) && (reg_bits <= MAX_REG_BITS) &&
             (fwd_stages >= 1) && (fwd_stages <= MAX_FWD_STAGES) &&
             (load_lat >= 1) && (load_lat <= fwd_stages);
   endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_match.sv
// Compares one scoreboard slot against the two source registers of the
// instruction in ID and reports which sources it would overwrite.
module pipe_dest_match
   import pipe_ctrl_pkg::*;
(
   input  logic                    valid,
   input  logic                    wb_en,
   input  logic                    is_load,
   input  logic [MAX_REG_BITS-1:0] dest,
   input  logic [MAX_REG_BITS-1:0] src1,
   input  logic [MAX_REG_BITS-1:0] src2,
   input  logic                    use2,
   output logic                    hit1,
   output logic                    hit2,
   output logic                    load_hit
);

   // A slot only matters if it really writes a register. src2 only counts when the consumer reads it.
   always_comb begin
      hit1     = valid & wb_en & (dest == src1);
      hit2     = valid & wb_en & use2 & (dest == src2);
      load_hit = is_load & (hit1 | hit2);
   end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard, forwarding and stall controller for the in-order pipeline.
// Slot 0 is EXE and slots 1..FWD_STAGES are the later stages. The slots
// shift forward each unheld cycle and drive stall, flush and forwarding.
module pipe_hazard_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int REG_BITS   = 4,
   parameter int FWD_STAGES = 2,
   parameter int LOAD_LAT   = 1,
   parameter int CNT_W      = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                forward_en,
   input  logic                id_valid,
   input  logic [REG_BITS-1:0] id_src1,
   input  logic [REG_BITS-1:0] id_src2,
   input  logic                id_two_src,
   input  logic [REG_BITS-1:0] id_dest,
   input  logic                id_wb_en,
   input  logic                id_mem_r_en,
   input  logic                branch_taken,
   input  logic                mem_ready,
   output logic                freeze,
   output logic                bubble,
   output logic                flush,
   output logic                hold_all,
   output logic [2:0]          sel_src1,
   output logic [2:0]          sel_src2,
   output logic [CNT_W-1:0]    stall_cnt,
   output logic [CNT_W-1:0]    flush_cnt
);

   localparam int NSLOT = FWD_STAGES + 1;

   if (!params_ok(REG_BITS, FWD_STAGES, LOAD_LAT)) begin : g_bad_params
      $error("pipe_hazard_ctrl: REG_BITS, FWD_STAGES or LOAD_LAT out of range");
   end

   slot_t                   slot_q [NSLOT];
   slot_t                   slot_d [NSLOT];
   slot_t                   id_entry;
   logic [CNT_W-1:0]        stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0]        flush_cnt_q, flush_cnt_d;
   logic [MAX_REG_BITS-1:0] id_src1_x, id_src2_x, id_dest_x;
   logic [NSLOT-1:0]        id_hit1, id_hit2, id_load_hit;
   logic                    hazard;

   assign id_src1_x = MAX_REG_BITS'(id_src1);
   assign id_src2_x = MAX_REG_BITS'(id_src2);
   assign id_dest_x = MAX_REG_BITS'(id_dest);

   for (genvar k = 0; k < NSLOT; k++) begin : g_slot
      pipe_dest_match u_id_match (
         .valid    (slot_q[k].valid),
         .wb_en    (slot_q[k].wb_en),
         .is_load  (slot_q[k].is_load),
         .dest     (slot_q[k].dest),
         .src1     (id_src1_x),
         .src2     (id_src2_x),
         .use2     (id_two_src),
         .hit1     (id_hit1[k]),
         .hit2     (id_hit2[k]),
         .load_hit (id_load_hit[k])
      );
   end

   // Raise a hazard on an unresolved RAW. With forwarding only young loads stall. Without it, any producer that has not yet written back stalls.
   always_comb begin
      hazard = 1'b0;
      for (int k = 0; k < NSLOT; k++) begin
         if (forward_en) begin
            if ((k < LOAD_LAT) && id_load_hit[k]) hazard = 1'b1;
         end else begin
            if ((k < FWD_STAGES) && (id_hit1[k] | id_hit2[k])) hazard = 1'b1;
         end
      end
      hazard   = hazard & id_valid;
      hold_all = ~mem_ready;
      flush    = branch_taken & mem_ready;
      freeze   = hazard & ~flush;
      bubble   = freeze;
   end

   // Pick the youngest later stage that writes each EXE operand. The scan runs oldest-first so the youngest match is the one that remains.
   always_comb begin
      sel_src1 = SEL_RF;
      sel_src2 = SEL_RF;
      for (int k = FWD_STAGES; k >= 1; k--) begin
         if (slot_q[k].valid && slot_q[k].wb_en && (slot_q[k].dest == slot_q[0].src1))
            sel_src1 = slot_sel(k);
         if (slot_q[k].valid && slot_q[k].wb_en && slot_q[0].use2 && (slot_q[k].dest == slot_q[0].src2))
            sel_src2 = slot_sel(k);
      end
      if (!(slot_q[0].valid && forward_en)) begin
         sel_src1 = SEL_RF;
         sel_src2 = SEL_RF;
      end
   end

   // Shift the scoreboard unless memory holds the pipe. EXE gets the ID instruction, or an empty slot on a bubble, flush or idle ID.
   always_comb begin
      id_entry = '{valid: 1'b1, dest: id_dest_x, wb_en: id_wb_en, is_load: id_mem_r_en,
                   src1: id_src1_x, src2: id_src2_x, use2: id_two_src};
      for (int k = 0; k < NSLOT; k++) slot_d[k] = slot_q[k];
      if (!hold_all) begin
         for (int k = NSLOT - 1; k >= 1; k--) slot_d[k] = slot_q[k - 1];
         slot_d[0] = (bubble || flush || !id_valid) ? SLOT_EMPTY : id_entry;
      end
   end

   // Saturating performance counters, so long runs never wrap back to small values.
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if ((freeze || hold_all) && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 1'b1;
      if (flush && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + 1'b1;
   end

   // State register. Reset empties every slot and clears the counters immediately.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int k = 0; k < NSLOT; k++) slot_q[k] <= SLOT_EMPTY;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         for (int k = 0; k < NSLOT; k++) slot_q[k] <= slot_d[k];
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign stall_cnt = stall_cnt_q;
   assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl (FWD_STAGES=2, LOAD_LAT=1, 4-bit counters).
// The driver pushes hand-computed expectations. The monitor pops them on the falling edge and compares.
module tb_pipe_hazard_ctrl;

   localparam int CW = 4;

   logic          clk;
   logic          rst;
   logic          forward_en;
   logic          id_valid;
   logic [3:0]    id_src1, id_src2, id_dest;
   logic          id_two_src, id_wb_en, id_mem_r_en;
   logic          branch_taken, mem_ready;
   logic          freeze, bubble, flush, hold_all;
   logic [2:0]    sel_src1, sel_src2;
   logic [CW-1:0] stall_cnt, flush_cnt;

   typedef struct {
      string         tag;
      logic          frz;
      logic          flsh;
      logic          hold;
      logic [2:0]    s1;
      logic [2:0]    s2;
      logic [CW-1:0] sc;
      logic [CW-1:0] fc;
   } exp_t;

   exp_t          exp_q[$];
   int            vectors     = 0;
   int            miscompares = 0;
   int            exp_stall   = 0;
   int            exp_flush   = 0;
   localparam int CNT_MAX     = (1 << CW) - 1;

   pipe_hazard_ctrl #(.REG_BITS(4), .FWD_STAGES(2), .LOAD_LAT(1), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst), .forward_en(forward_en), .id_valid(id_valid),
      .id_src1(id_src1), .id_src2(id_src2), .id_two_src(id_two_src), .id_dest(id_dest),
      .id_wb_en(id_wb_en), .id_mem_r_en(id_mem_r_en), .branch_taken(branch_taken),
      .mem_ready(mem_ready), .freeze(freeze), .bubble(bubble), .flush(flush),
      .hold_all(hold_all), .sel_src1(sel_src1), .sel_src2(sel_src2),
      .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Drive one cycle of inputs just after the rising edge and queue the expected response.
   task automatic applyStimulus(input string tag, input logic fe, input logic idv,
                                input int s1, input int s2, input logic two, input int dst,
                                input logic wb, input logic ld, input logic br, input logic mr,
                                input logic efrz, input logic eflush, input logic ehold,
                                input int es1, input int es2);
      exp_t e;
      @(posedge clk); #1;
      rst          = 1'b1;
      forward_en   = fe;
      id_valid     = idv;
      id_src1      = 4'(s1);
      id_src2      = 4'(s2);
      id_two_src   = two;
      id_dest      = 4'(dst);
      id_wb_en     = wb;
      id_mem_r_en  = ld;
      branch_taken = br;
      mem_ready    = mr;
      e.tag  = tag;
      e.frz  = efrz;
      e.flsh = eflush;
      e.hold = ehold;
      e.s1   = 3'(es1);
      e.s2   = 3'(es2);
      e.sc   = CW'(exp_stall);
      e.fc   = CW'(exp_flush);
      exp_q.push_back(e);
      if ((efrz || ehold) && exp_stall < CNT_MAX) exp_stall++;
      if (eflush && exp_flush < CNT_MAX) exp_flush++;
   endtask

   // A cycle with no instruction in ID.
   task automatic idle(input string tag, input logic fe, input logic br, input logic mr,
                       input logic eflush, input logic ehold, input int es1, input int es2);
      applyStimulus(tag, fe, 1'b0, 0, 0, 1'b0, 0, 1'b0, 1'b0, br, mr, 1'b0, eflush, ehold, es1, es2);
   endtask

   // Assert reset asynchronously mid-cycle with quiet inputs. Every output must drop immediately.
   task automatic doReset();
      exp_t e;
      @(posedge clk); #1;
      rst          = 1'b0;
      forward_en   = 1'b1;
      id_valid     = 1'b0;
      id_src1      = '0;
      id_src2      = '0;
      id_two_src   = 1'b0;
      id_dest      = '0;
      id_wb_en     = 1'b0;
      id_mem_r_en  = 1'b0;
      branch_taken = 1'b0;
      mem_ready    = 1'b1;
      e.tag  = "reset";
      e.frz  = 1'b0;
      e.flsh = 1'b0;
      e.hold = 1'b0;
      e.s1   = 3'd0;
      e.s2   = 3'd0;
      e.sc   = '0;
      e.fc   = '0;
      exp_q.push_back(e);
      exp_stall = 0;
      exp_flush = 0;
   endtask

   task automatic cmp(input string tag, input string name, input int act, input int req);
      if (act != req) begin
         miscompares++;
         $display("[TB] FAIL %s.%s: got %0d, expected %0d", tag, name, act, req);
      end
   endtask

   task automatic checkOutput(input exp_t e);
      vectors++;
      cmp(e.tag, "freeze",    int'(freeze),    int'(e.frz));
      cmp(e.tag, "bubble",    int'(bubble),    int'(e.frz));
      cmp(e.tag, "flush",     int'(flush),     int'(e.flsh));
      cmp(e.tag, "hold_all",  int'(hold_all),  int'(e.hold));
      cmp(e.tag, "sel_src1",  int'(sel_src1),  int'(e.s1));
      cmp(e.tag, "sel_src2",  int'(sel_src2),  int'(e.s2));
      cmp(e.tag, "stall_cnt", int'(stall_cnt), int'(e.sc));
      cmp(e.tag, "flush_cnt", int'(flush_cnt), int'(e.fc));
   endtask

   // Monitor: on every falling edge, compare against the oldest outstanding expectation.
   always @(negedge clk) begin
      if (exp_q.size() > 0) checkOutput(exp_q.pop_front());
   end

   initial begin
      rst = 1'b0; forward_en = 1'b1; id_valid = 1'b0; id_src1 = '0; id_src2 = '0;
      id_two_src = 1'b0; id_dest = '0; id_wb_en = 1'b0; id_mem_r_en = 1'b0;
      branch_taken = 1'b0; mem_ready = 1'b1;

      // Reset in mid-run with three valid slots, one of the cycles held.
      doReset();
      applyStimulus("rst_i1", 1, 1, 2, 3, 1, 1, 1, 0, 0, 1, 0, 0, 0, 0, 0);
      applyStimulus("rst_i2", 1, 1, 4, 5, 1, 2, 1, 0, 0, 1, 0, 0, 0, 0, 0);
      applyStimulus("rst_i3", 1, 1, 1, 2, 1, 3, 1, 0, 0, 1, 0, 0, 0, 0, 0);
      idle("rst_hold", 1, 0, 0, 0, 1, 2, 1);
      idle("rst_full", 1, 0, 1, 0, 0, 2, 1);
      doReset();
      applyStimulus("rst_clear", 0, 1, 1, 2, 1, 6, 1, 0, 0, 1, 0, 0, 0, 0, 0);

      // Load-use: one-cycle stall, then forward from WB.
      doReset();
      applyStimulus("ldu_ldr",   1, 1, 2, 0, 0, 1, 1, 1, 0, 1, 0, 0, 0, 0, 0);
      applyStimulus("ldu_stall", 1, 1, 1, 3, 1, 2, 1, 0, 0, 1, 1, 0, 0, 0, 0);
      applyStimulus("ldu_go",    1, 1, 1, 3, 1, 2, 1, 0, 0, 1, 0, 0, 0, 0, 0);
      idle("ldu_fwd_wb", 1, 0, 1, 0, 0, 2, 0);
      idle("ldu_drain",  1, 0, 1, 0, 0, 0, 0);

      // ALU chain: no stall, forward both operands from MEM.
      doReset();
      applyStimulus("alu_add", 1, 1, 2, 3, 1, 1, 1, 0, 0, 1, 0, 0, 0, 0, 0);
      applyStimulus("alu_sub", 1, 1, 1, 1, 1, 4, 1, 0, 0, 1, 0, 0, 0, 0, 0);
      idle("alu_fwd_mem", 1, 0, 1, 0, 0, 1, 1);
      idle("alu_drain",   1, 0, 1, 0, 0, 0, 0);

      // Two producers of R1: the younger wins. src2 is ignored when not read.
      doReset();
      applyStimulus("pri_add1", 1, 1, 2, 3, 1, 1, 1, 0, 0, 1, 0, 0, 0, 0, 0);
      applyStimulus("pri_add2", 1, 1, 5, 6, 1, 1, 1, 0, 0, 1, 0, 0, 0, 0, 0);
      applyStimulus("pri_sub",  1, 1, 1, 1, 0, 4, 1, 0, 0, 1, 0, 0, 0, 0, 0);
      idle("pri_youngest", 1, 0, 1, 0, 0, 1, 0);

      // Forwarding disabled: the consumer stalls until the producer reaches the last slot.
      doReset();
      applyStimulus("nofwd_mov",  0, 1, 0, 0, 0, 5, 1, 0, 0, 1, 0, 0, 0, 0, 0);
      applyStimulus("nofwd_cmp1", 0, 1, 5, 7, 1, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0);
      applyStimulus("nofwd_cmp2", 0, 1, 5, 7, 1, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0);
      applyStimulus("nofwd_go",   0, 1, 5, 7, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
      idle("nofwd_exe", 0, 0, 1, 0, 0, 0, 0);

      // Hazard and taken branch together: the flush wins.
      doReset();
      applyStimulus("sim_ldr",   1, 1, 2, 0, 0, 1, 1, 1, 0, 1, 0, 0, 0, 0, 0);
      applyStimulus("sim_both",  1, 1, 1, 3, 1, 2, 1, 0, 1, 1, 0, 1, 0, 0, 0);
      idle("sim_after", 1, 0, 1, 0, 0, 0, 0);

      // Memory hold over a load-use hazard, with a branch arriving during the hold.
      doReset();
      applyStimulus("hold_ldr", 1, 1, 2, 0, 0, 1, 1, 1, 0, 1, 0, 0, 0, 0, 0);
      applyStimulus("hold_1",   1, 1, 1, 3, 1, 2, 1, 0, 0, 0, 1, 0, 1, 0, 0);
      applyStimulus("hold_2",   1, 1, 1, 3, 1, 2, 1, 0, 0, 0, 1, 0, 1, 0, 0);
      applyStimulus("hold_br3", 1, 1, 1, 3, 1, 2, 1, 0, 1, 0, 1, 0, 1, 0, 0);
      applyStimulus("hold_br4", 1, 1, 1, 3, 1, 2, 1, 0, 1, 0, 1, 0, 1, 0, 0);
      applyStimulus("hold_rel", 1, 1, 1, 3, 1, 2, 1, 0, 1, 1, 0, 1, 0, 0, 0);
      idle("hold_after", 1, 0, 1, 0, 0, 0, 0);

      // Both counters saturate rather than wrap.
      doReset();
      for (int i = 0; i < CNT_MAX + 3; i++) idle("sat_stall", 1, 0, 0, 0, 1, 0, 0);
      for (int i = 0; i < CNT_MAX + 3; i++) idle("sat_flush", 1, 1, 1, 1, 0, 0, 0);
      idle("sat_end", 1, 0, 1, 0, 0, 0, 0);

      @(negedge clk); #1;
      vectors++;
      if (exp_q.size() != 0) begin
         miscompares++;
         $display("[TB] FAIL drain: %0d expectations left, expected 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
